mac_frame_accumulator: RTL and testbench

Parametrised multiply-accumulate engine for the equalizer's time-multiplexed FIR bands. It owns its own tap sequencer. It drives a phase index to the delay-line and coefficient muxes, and accumulates one product per enabled cycle over TAPS cycles. At each frame boundary it emits a rounded, saturated sample with a one-cycle valid pulse and a saturation indication.

---
 rtl/mac_frame_accumulator.sv | 154 +++++++++++++++
 tb/tb_mac_frame_accumulator.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_accumulator.sv
// mac_frame_accumulator: time-multiplexed FIR multiply-accumulate engine with
// its own tap sequencer, round/saturate output stage and clip indication.
//
// Optional feature macro: ROUND_NEAREST_EN (round-half-up before saturating;
// when undefined the output is the floor of the scaled sum).
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   clk_enable     advances sequencer and accumulator
//   sync_clr       synchronous frame restart (wins over clk_enable)
//   phase          registered tap index driven to delay-line/coeff muxes
//   data_in, coeff sample and coefficient for the current phase
//   filter_out     registered, rounded and saturated output sample
//   out_valid      one-cycle pulse when filter_out is updated
//   sat_flag       filter_out of this pulse was clipped
//   sat_sticky     any clip since reset or sync_clr
module mac_frame_accumulator #(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int TAPS       = 8,
    parameter int GUARD_W    = 2,
    parameter int FRAC_SHIFT = 16,
    parameter int OUT_W      = 16,
    localparam int PH_W      = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int ACC_W     = DATA_W + COEFF_W + GUARD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic               sync_clr,
    output logic [PH_W-1:0]    phase,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [COEFF_W-1:0] coeff,
    output logic [OUT_W-1:0]   filter_out,
    output logic               out_valid,
    output logic               sat_flag,
    output logic               sat_sticky
);

    localparam int PROD_W = DATA_W + COEFF_W;
    // Width of the sum after dropping the fraction, with one extra MSB so
    // the rounding increment can never wrap.
    localparam int HI_W   = ACC_W + 1 - FRAC_SHIFT;

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             primed_q, primed_d;
    logic [OUT_W-1:0] filter_out_q, filter_out_d;
    logic             out_valid_q, out_valid_d;
    logic             sat_flag_q, sat_flag_d;
    logic             sat_sticky_q, sat_sticky_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     last_tap;
    logic                     rnd_bit;
    logic [HI_W-1:0]          r_hi;
    logic [HI_W-OUT_W:0]      r_top;
    logic                     ovf;
    logic [OUT_W-1:0]         conv;

    // Full-precision signed product, sign-extended into the accumulator.
    always_comb begin
        prod     = PROD_W'($signed(data_in)) * PROD_W'($signed(coeff));
        prod_ext = ACC_W'(prod);
    end

    // Adding 2^(FRAC_SHIFT-1) and then dropping FRAC_SHIFT LSBs is the same
    // as adding bit FRAC_SHIFT-1 to the already-shifted sum.
`ifdef ROUND_NEAREST_EN
    assign rnd_bit = acc_q[FRAC_SHIFT-1];
`else
    assign rnd_bit = 1'b0;
`endif

    // Conversion of the completed sum held in acc_q.
    always_comb begin
        r_hi  = {acc_q[ACC_W-1], acc_q[ACC_W-1:FRAC_SHIFT]} + HI_W'(rnd_bit);
        r_top = r_hi[HI_W-1:OUT_W-1];
        ovf   = ~((&r_top) | ~(|r_top));
        if (!ovf)
            conv = r_hi[OUT_W-1:0];
        else if (r_hi[HI_W-1])
            conv = {1'b1, {(OUT_W-1){1'b0}}};
        else
            conv = {1'b0, {(OUT_W-1){1'b1}}};
    end

    assign last_tap = (phase_q == PH_W'(TAPS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            acc_q        <= '0;
            primed_q     <= 1'b0;
            filter_out_q <= '0;
            out_valid_q  <= 1'b0;
            sat_flag_q   <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            primed_q     <= primed_d;
            filter_out_q <= filter_out_d;
            out_valid_q  <= out_valid_d;
            sat_flag_q   <= sat_flag_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    // Next-state logic.
    always_comb begin
        phase_d      = phase_q;
        acc_d        = acc_q;
        primed_d     = primed_q;
        filter_out_d = filter_out_q;
        out_valid_d  = 1'b0;
        sat_flag_d   = 1'b0;
        sat_sticky_d = sat_sticky_q;
        if (sync_clr) begin
            phase_d      = '0;
            acc_d        = '0;
            primed_d     = 1'b0;
            sat_sticky_d = 1'b0;
        end else if (clk_enable) begin
            phase_d = last_tap ? '0 : phase_q + PH_W'(1);
            if (phase_q == '0) begin
                // Frame boundary: restart the sum and, once a full frame
                // has been collected, publish the previous one.
                acc_d    = prod_ext;
                primed_d = 1'b1;
                if (primed_q) begin
                    filter_out_d = conv;
                    out_valid_d  = 1'b1;
                    sat_flag_d   = ovf;
                    sat_sticky_d = sat_sticky_q | ovf;
                end
            end else begin
                acc_d = acc_q + prod_ext;
            end
        end
    end

    // Outputs.
    always_comb begin
        phase      = phase_q;
        filter_out = filter_out_q;
        out_valid  = out_valid_q;
        sat_flag   = sat_flag_q;
        sat_sticky = sat_sticky_q;
    end

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// tb_mac_frame_accumulator: directed self-checking bench for
// mac_frame_accumulator (TAPS=4 instance plus a TAPS=1 instance).
module tb_mac_frame_accumulator;

    logic        clk;
    logic        rst;
    logic        clk_enable;
    logic        sync_clr;
    logic [1:0]  phase;
    logic [15:0] data_in;
    logic [15:0] coeff;
    logic [15:0] filter_out;
    logic        out_valid;
    logic        sat_flag;
    logic        sat_sticky;

    logic [0:0]  phase1;
    logic [15:0] d1;
    logic [15:0] c1;
    logic [15:0] fo1;
    logic        ov1;
    logic        sf1;
    logic        ss1;

    int n_cmp;
    int n_bad;

`ifdef ROUND_NEAREST_EN
    localparam logic [15:0] EXP_RND_POS = 16'h0001;
    localparam logic [15:0] EXP_RND_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_RND_POS = 16'h0000;
    localparam logic [15:0] EXP_RND_NEG = 16'hFFFF;
`endif

    mac_frame_accumulator #(.TAPS(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .sync_clr   (sync_clr),
        .phase      (phase),
        .data_in    (data_in),
        .coeff      (coeff),
        .filter_out (filter_out),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag),
        .sat_sticky (sat_sticky)
    );

    mac_frame_accumulator #(.TAPS(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .sync_clr   (sync_clr),
        .phase      (phase1),
        .data_in    (d1),
        .coeff      (c1),
        .filter_out (fo1),
        .out_valid  (ov1),
        .sat_flag   (sf1),
        .sat_sticky (ss1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sync_clr   = 1'b0;
        clk_enable = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        data_in = 16'd100;
        coeff   = 16'h4000;
        do_reset();
        n_cmp++;
        if (phase !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_phase: got %0d want 0", phase);
        end
        n_cmp++;
        if (filter_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_out: got %h want 0000", filter_out);
        end
        n_cmp++;
        if ({out_valid, sat_flag, sat_sticky} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000",
                     {out_valid, sat_flag, sat_sticky});
        end
    endtask

    task automatic test_basic();
        int n;
        data_in = 16'd100;
        coeff   = 16'h4000;
        do_reset();
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5) begin
            n_bad++;
            $display("FAIL basic_first_lat: got %0d want 5", n);
        end
        n_cmp++;
        if (filter_out !== 16'd100 || sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_value: got %h sat %b want 0064 sat 0",
                     filter_out, sat_flag);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pulse: got %b want 0", out_valid);
        end
        wait_valid(12, n);
        n_cmp++;
        if (n !== 3) begin
            n_bad++;
            $display("FAIL basic_spacing: got %0d want 3", n);
        end
        n_cmp++;
        if (filter_out !== 16'd100) begin
            n_bad++;
            $display("FAIL basic_value2: got %h want 0064", filter_out);
        end
    endtask

    task automatic test_clip();
        int n;
        data_in = 16'h7FFF;
        coeff   = 16'h7FFF;
        do_reset();
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL pos_clip: got n=%0d %h want n=5 7fff",
                     n, filter_out);
        end
        n_cmp++;
        if (sat_flag !== 1'b1 || sat_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL pos_clip_flags: got %b%b want 11",
                     sat_flag, sat_sticky);
        end
        data_in = 16'h8000;
        do_reset();
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== 16'h8000) begin
            n_bad++;
            $display("FAIL neg_clip: got n=%0d %h want n=5 8000",
                     n, filter_out);
        end
        n_cmp++;
        if (sat_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_clip_flag: got %b want 1", sat_flag);
        end
    endtask

    task automatic test_rounding();
        int n;
        data_in = 16'h0001;
        coeff   = 16'h2000;
        do_reset();
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== EXP_RND_POS) begin
            n_bad++;
            $display("FAIL round_pos: got n=%0d %h want n=5 %h",
                     n, filter_out, EXP_RND_POS);
        end
        data_in = 16'hFFFF;
        do_reset();
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== EXP_RND_NEG) begin
            n_bad++;
            $display("FAIL round_neg: got n=%0d %h want n=5 %h",
                     n, filter_out, EXP_RND_NEG);
        end
        n_cmp++;
        if (sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL round_noclip: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_enable_gaps();
        int first;
        int second;
        int cnt;
        data_in = 16'd100;
        coeff   = 16'h4000;
        do_reset();
        first  = -1;
        second = -1;
        cnt    = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                cnt++;
                if (first < 0)
                    first = i;
                else if (second < 0)
                    second = i;
            end
            if (i == 2) begin
                n_cmp++;
                if (phase !== 2'd1) begin
                    n_bad++;
                    $display("FAIL gap_hold: got %0d want 1", phase);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (phase !== 2'd2) begin
                    n_bad++;
                    $display("FAIL gap_adv: got %0d want 2", phase);
                end
            end
            clk_enable = ~clk_enable;
        end
        clk_enable = 1'b1;
        n_cmp++;
        if (first !== 9 || second !== 17 || cnt !== 2) begin
            n_bad++;
            $display("FAIL gap_valid: got %0d/%0d/%0d want 9/17/2",
                     first, second, cnt);
        end
        n_cmp++;
        if (filter_out !== 16'd100) begin
            n_bad++;
            $display("FAIL gap_value: got %h want 0064", filter_out);
        end
    endtask

    task automatic test_sync_clr();
        int n;
        data_in = 16'h7FFF;
        coeff   = 16'h7FFF;
        do_reset();
        wait_valid(12, n);
        tick();
        n_cmp++;
        if (phase !== 2'd2 || sat_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pre: got ph %0d st %b want 2 1",
                     phase, sat_sticky);
        end
        sync_clr = 1'b1;
        data_in  = 16'd100;
        coeff    = 16'h4000;
        tick();
        sync_clr = 1'b0;
        n_cmp++;
        if (phase !== 2'd0 || sat_sticky !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_state: got ph %0d st %b v %b want 0 0 0",
                     phase, sat_sticky, out_valid);
        end
        n_cmp++;
        if (filter_out !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL clr_hold: got %h want 7fff", filter_out);
        end
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== 16'd100 || sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_next: got n=%0d %h sat %b want n=5 0064 0",
                     n, filter_out, sat_flag);
        end
    endtask

    task automatic test_rst_midframe();
        int n;
        data_in = 16'd100;
        coeff   = 16'h4000;
        do_reset();
        wait_valid(12, n);
        tick();
        tick();
        n_cmp++;
        if (phase !== 2'd3 || filter_out !== 16'd100) begin
            n_bad++;
            $display("FAIL rst_pre: got ph %0d %h want 3 0064",
                     phase, filter_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (phase !== 2'd0 || filter_out !== 16'h0000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: got ph %0d %h v %b want 0 0000 0",
                     phase, filter_out, out_valid);
        end
        rst = 1'b0;
        wait_valid(12, n);
        n_cmp++;
        if (n !== 5 || filter_out !== 16'd100) begin
            n_bad++;
            $display("FAIL rst_next: got n=%0d %h want n=5 0064",
                     n, filter_out);
        end
    endtask

    task automatic test_taps1();
        d1 = 16'd100;
        c1 = 16'h4000;
        do_reset();
        tick();
        n_cmp++;
        if (ov1 !== 1'b0 || phase1 !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_first: got v %b ph %b want 0 0", ov1, phase1);
        end
        d1 = 16'd200;
        tick();
        n_cmp++;
        if (ov1 !== 1'b1 || fo1 !== 16'd25) begin
            n_bad++;
            $display("FAIL t1_out1: got v %b %h want 1 0019", ov1, fo1);
        end
        d1 = 16'hFF9C;
        tick();
        n_cmp++;
        if (ov1 !== 1'b1 || fo1 !== 16'd50 || phase1 !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_out2: got v %b %h ph %b want 1 0032 0",
                     ov1, fo1, phase1);
        end
        d1 = 16'd100;
        tick();
        n_cmp++;
        if (ov1 !== 1'b1 || fo1 !== 16'hFFE7 || sf1 !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_out3: got v %b %h sat %b want 1 ffe7 0",
                     ov1, fo1, sf1);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        clk_enable = 1'b1;
        sync_clr   = 1'b0;
        data_in    = '0;
        coeff      = '0;
        d1         = '0;
        c1         = '0;
        test_reset();
        test_basic();
        test_clip();
        test_rounding();
        test_enable_gaps();
        test_sync_clr();
        test_rst_midframe();
        test_taps1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
